instruction_fetch: RTL
======================

# instruction_fetch

Fetch front end that drives the instruction memory's combinational read port and delivers fetched words to decode. It holds the program counter (PC), which starts at 0x00003000 and advances by 4 per fetch. Fetched instruction/PC pairs are buffered in a small FIFO with a valid/ready handshake toward decode. Redirects from branch/jump resolution flush the buffer and restart fetch at the target.

## Interface
- INIT_PC, 32'h00003000, PC value loaded at reset.
- DEPTH, 2, fetch-buffer entries; power of two, ≥2.
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_en  input  1  global fetch enable; 0 freezes PC, buffer still drains
- imem_addr  output  32  fetch address to instruction memory; equals PC (combinational)
- imem_instr  input  32  instruction word returned combinationally for imem_addr
- out_valid  output  1  buffer head holds a valid entry
- out_ready  input  1  decode accepts head this cycle
- out_instr  output  32  head instruction
- out_pc  output  32  PC of head instruction
- redirect_valid  input  1  one-cycle redirect request
- redirect_pc  input  32  redirect target
- occupancy  output  $clog2(DEPTH)+1  entries currently buffered
- fault  output  1  sticky misaligned-redirect flag (only with FETCH_ALIGN_CHECK_EN)
- fault_pc  output  32  offending redirect target (only with FETCH_ALIGN_CHECK_EN)

## Operation
- State: PC register; circular buffer (rd_ptr, wr_ptr, count); fault state when the macro is defined.
- deq = out_valid && out_ready.
- enq = fetch_en && !redirect_valid && !fault && (count < DEPTH || deq).
- On enq: write {imem_instr, PC} at wr_ptr; PC <= PC + 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
- On deq: rd_ptr advances. count <= count + enq − deq.
- Redirect (redirect_valid=1) has priority over everything else:
  - count, rd_ptr and wr_ptr clear; PC <= redirect_pc.
  - No enqueue occurs that cycle.
  - A deq in the same cycle counts as consumed by decode but has no further effect.
- Addresses below INIT_PC are not special here: memory returns 0, and that word is buffered like any other.
- Full with no deq: PC holds and imem_addr stays stable.
- Empty: out_valid=0; out_instr/out_pc are don't-care and must not be checked.
- fetch_en=0: no enqueue and PC holds; deq continues normally.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert use): PC=INIT_PC, count=0, out_valid=0, occupancy=0, fault=0, fault_pc=0.
  - out_instr/out_pc reset to 0 (buffer storage is not cleared).
- A reset asserted mid-stream discards all buffered entries immediately.
- Fetch latency: an instruction at PC is captured on the edge where enq=1; out_valid is high the following cycle (1-cycle fetch-to-decode).
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Redirect penalty:
  - The redirect cycle enqueues nothing.
  - The target is fetched in the next cycle and valid at out the cycle after, giving 2 cycles from the redirect request to the first target instruction at out.
- out_* are driven from buffer registers and have no combinational path from imem_instr.
- imem_addr is combinational from PC only.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fault=1 and captures fault_pc=redirect_pc.
  - It flushes the buffer; PC still loads redirect_pc.
  - With fault set, all enqueue stops until rst_n; further redirects are ignored.
- Macro undefined:
  - fault/fault_pc ports are absent.
  - PC loads {redirect_pc[31:2], 2'b00}.
  - Fetch continues normally.

## Test plan
- Reset, then fetch_en=1 with out_ready=1 and memory holding 0x11111111, 0x22222222, 0x33333333 at 0x3000/0x3004/0x3008 → imem_addr = 0x3000, 0x3004, 0x3008 on consecutive cycles; out delivers those words with out_pc 0x3000.. starting cycle 1.
- Backpressure: out_ready=0 for 5 cycles → occupancy saturates at 2 and imem_addr holds at 0x3008. Raise out_ready → entries 0x3000 and 0x3004 emerge in order, then fetch resumes at 0x3008 with no loss or duplicate.
- Redirect to 0x3040 while the buffer is full and out_ready=1 → next cycle occupancy=0 and imem_addr=0x3040; out_pc=0x3040 two cycles after the redirect; no wrong-path entries appear.
- Wrap: redirect to 0xFFFFFFFC → next out_pc values are 0xFFFFFFFC then 0x00000000 (instr 0).
- Asynchronous reset pulse mid-stream with occupancy=2 → out_valid drops without a clock edge; after release, fetch restarts at 0x3000.
- Redirect to 0x3042: with FETCH_ALIGN_CHECK_EN → fault=1, fault_pc=0x3042, no further out_valid. Without the macro → fetch proceeds from 0x3040.

Source files
------------

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch front end. Holds the program counter, drives the instruction memory's
// combinational read port with it, and buffers fetched {instruction, PC} pairs
// in a small circular FIFO that decode drains through a valid/ready handshake.
// A redirect from branch/jump resolution flushes the buffer and restarts fetch
// at the target address.
//
// Parameters
//   INIT_PC         PC loaded at reset
//   DEPTH           fetch-buffer entries (power of two, >= 2)
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   fetch_en        fetch enable; low freezes the PC while the buffer drains
//   imem_addr       fetch address (combinational copy of the PC)
//   imem_instr      instruction word returned combinationally for imem_addr
//   out_valid       buffer head holds a valid entry
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction (registered)
//   out_pc          PC of the head instruction (registered)
//   redirect_valid  one-cycle redirect request
//   redirect_pc     redirect target
//   occupancy       number of buffered entries
//   fault           sticky misaligned-redirect flag   (FETCH_ALIGN_CHECK_EN)
//   fault_pc        offending redirect target         (FETCH_ALIGN_CHECK_EN)
//
// Build option
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect to a non word-aligned target
//                         raises a sticky fault that stops all fetching until
//                         reset. When undefined, the target is silently forced
//                         to word alignment and fetch continues.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] INIT_PC = 32'h0000_3000,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                     fault,
    output logic [31:0]              fault_pc
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]      pc_q,     pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [31:0]      head_instr_q, head_instr_d;
    logic [31:0]      head_pc_q,    head_pc_d;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];

    logic             fault_blk;        // fetch halted by a latched fault
    logic             redirect_take;    // redirect that actually takes effect
    logic [31:0]      redirect_target;
    logic             deq;
    logic             enq;

    // -------------------------------------------------------------------------
    // Alignment handling
    // -------------------------------------------------------------------------
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault_q;
    logic [31:0] fault_pc_q;

    assign fault_blk       = fault_q;
    // A misaligned target is loaded as-is; the fault stops fetch anyway.
    assign redirect_target = redirect_pc;
    assign fault           = fault_q;
    assign fault_pc        = fault_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else if (redirect_take && (redirect_pc[1:0] != 2'b00)) begin
            fault_q    <= 1'b1;
            fault_pc_q <= redirect_pc;
        end
    end
`else
    logic unused_redirect_lsbs;

    assign fault_blk            = 1'b0;
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    // -------------------------------------------------------------------------
    // Handshake and enqueue decision
    // -------------------------------------------------------------------------
    // Once a fault is latched, further redirects are ignored entirely.
    assign redirect_take = redirect_valid && !fault_blk;

    assign deq = out_valid && out_ready;
    // A full buffer can still accept when the head leaves in the same cycle.
    assign enq = fetch_en && !redirect_valid && !fault_blk &&
                 ((count_q < CNT_W'(DEPTH)) || deq);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block so no path leaves it unassigned and infers a latch.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_take) begin
            // A same-cycle deq is consumed by decode but needs no bookkeeping:
            // the whole buffer is discarded.
            pc_d     = redirect_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + 32'd4;   // wraps modulo 2^32
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // The head is kept in dedicated registers so out_* come straight from
    // flops. The next head is the entry at rd_ptr_d, unless that slot is the
    // one being written this cycle (buffer empty or draining its last entry),
    // in which case the incoming word is forwarded into the head register.
    always_comb begin
        head_instr_d = instr_mem_q[rd_ptr_d];
        head_pc_d    = pc_mem_q[rd_ptr_d];
        if (enq && (wr_ptr_q == rd_ptr_d)) begin
            head_instr_d = imem_instr;
            head_pc_d    = pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= INIT_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_instr_q <= 32'h0;
            head_pc_q    <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
        end
    end

    // NOTE: buffer storage carries no reset; validity is tracked by count_q
    // alone, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[wr_ptr_q] <= imem_instr;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign occupancy = count_q;
    assign out_instr = head_instr_q;
    assign out_pc    = head_pc_q;

endmodule
